if_fetch_sequencer: RTL and testbench

Instruction-fetch controller for the pipelined CPU core. It owns the program counter, drives the 9-bit word address of the combinational instruction ROM, and arbitrates between the next-PC sources: sequential fetch, ID-stage jump/jr, EX-stage branch and the interrupt/exception vectors. It also honours hazard-unit stalls. It writes the IF/ID pipeline register (instruction, PC+4, valid) and issues IF-stage flushes.

---
 rtl/if_fetch_sequencer.sv | 105 ++++++++++
 tb/tb_if_fetch_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/if_fetch_sequencer.sv
// if_fetch_sequencer: PC owner and IF/ID writer arbitrating sequential, jump, branch and vectored fetch
//   Params : IMEM_AW (ROM word-address width), RESET_PC, IRQ_VEC, EXC_VEC
//   Clock  : i_clk, i_rst_n (synchronous, active-low)
//   ROM    : o_imem_addr -> i_imem_instr (combinational)
//   Control: i_stall, i_jump_en/i_jump_target, i_branch_en/i_branch_target, i_irq, i_exc
//   IF/ID  : o_if_instr, o_if_pc_plus4, o_if_valid
//   Status : o_pc, o_epc, o_flush_id (combinational)
//   Option : define IF_FETCH_EXC_EN to enable the interrupt/exception vectors and o_epc
module if_fetch_sequencer #(
  parameter int          IMEM_AW  = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic [31:0]        i_imem_instr,
  input  logic               i_stall,
  input  logic               i_jump_en,
  input  logic [31:0]        i_jump_target,
  input  logic               i_branch_en,
  input  logic [31:0]        i_branch_target,
  input  logic               i_irq,
  input  logic               i_exc,
  output logic [31:0]        o_if_instr,
  output logic [31:0]        o_if_pc_plus4,
  output logic               o_if_valid,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_epc,
  output logic               o_flush_id
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_if_instr, r_if_pc_plus4, r_epc;
  logic        r_if_valid;
  logic [31:0] w_pc_nxt, w_if_instr_nxt, w_if_pc_plus4_nxt, w_epc_nxt, w_pc_seq, w_target, w_ret;
  logic        w_if_valid_nxt, w_exc_take, w_irq_take, w_vector, w_redirect;
`ifdef IF_FETCH_EXC_EN
  assign w_exc_take = i_exc;
  assign w_irq_take = i_irq & ~r_pc[31];
`else
  assign w_exc_take = 1'b0 & i_exc;
  assign w_irq_take = 1'b0 & i_irq;
`endif
  assign w_vector   = w_exc_take | w_irq_take;
  assign w_redirect = w_vector | i_branch_en | i_jump_en;
  // Kernel-mode bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign w_pc_seq   = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_target   = (w_exc_take ? EXC_VEC : w_irq_take ? IRQ_VEC :
                       i_branch_en ? i_branch_target : i_jump_target) & ALIGN;
  // Return point resumes at the redirect the vector pre-empted, else re-fetches the current PC.
  assign w_ret      = (i_branch_en ? i_branch_target : i_jump_en ? i_jump_target : r_pc) & ALIGN;
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_instr_nxt    = r_if_instr;
    w_if_pc_plus4_nxt = r_if_pc_plus4;
    w_if_valid_nxt    = r_if_valid;
    w_epc_nxt         = r_epc;
    if (r_state == BOOT) begin
      w_state_nxt = RUN;
    end else if (w_redirect) begin
      w_state_nxt       = RUN;
      w_pc_nxt          = w_target;
      w_if_instr_nxt    = 32'h0;
      w_if_pc_plus4_nxt = 32'h0;
      w_if_valid_nxt    = 1'b0;
      w_epc_nxt         = w_vector ? w_ret : r_epc;
    end else if (i_stall) begin
      w_state_nxt = HOLD;
    end else begin
      w_state_nxt       = RUN;
      w_pc_nxt          = w_pc_seq;
      w_if_instr_nxt    = i_imem_instr;
      w_if_pc_plus4_nxt = w_pc_seq;
      w_if_valid_nxt    = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_if_instr    <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_if_valid    <= 1'b0;
      r_epc         <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_if_pc_plus4 <= w_if_pc_plus4_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_epc         <= w_epc_nxt;
    end
  end
  assign o_imem_addr   = r_pc[IMEM_AW+1:2];
  assign o_pc          = r_pc;
  assign o_if_instr    = r_if_instr;
  assign o_if_pc_plus4 = r_if_pc_plus4;
  assign o_if_valid    = r_if_valid;
  assign o_epc         = r_epc;
  assign o_flush_id    = i_rst_n & (r_state != BOOT) & (i_branch_en | w_exc_take);
endmodule

// File: tb/tb_if_fetch_sequencer.sv
// tb_if_fetch_sequencer: directed plus random fetch scenarios checked against a behavioural PC/IF-ID model
module tb_if_fetch_sequencer;
`ifdef IF_FETCH_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, stall, jump_en, branch_en, irq, exc, if_valid, flush_id;
  logic [31:0] jump_target, branch_target, imem_instr, if_instr, if_pc_plus4, pc, epc;
  logic [8:0]  imem_addr;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_boot;
  if_fetch_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_instr(imem_instr),
    .i_stall(stall), .i_jump_en(jump_en), .i_jump_target(jump_target),
    .i_branch_en(branch_en), .i_branch_target(branch_target), .i_irq(irq), .i_exc(exc),
    .o_if_instr(if_instr), .o_if_pc_plus4(if_pc_plus4), .o_if_valid(if_valid),
    .o_pc(pc), .o_epc(epc), .o_flush_id(flush_id)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [8:0] a);
    return {a, 7'h5A, ~a, 7'h33};
  endfunction
  assign imem_instr = rom(imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic q, input logic e);
    logic ex_t, iq_t;
    @(negedge clk);
    rst_n = r; stall = s; branch_en = b; branch_target = bt;
    jump_en = j; jump_target = jt; irq = q; exc = e;
    ex_t = EXC && e;
    iq_t = EXC && q && (m_pc < 32'h8000_0000);
    #1 chk("flush_id", {31'b0, flush_id}, {31'b0, r && !m_boot && (b || ex_t)});
    @(posedge clk);
    if (!r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (ex_t || iq_t || b || j) begin
      if (ex_t || iq_t) m_epc = (b ? bt : j ? jt : m_pc) & ~32'd3;
      m_pc = ex_t ? 32'h8000_0008 : iq_t ? 32'h8000_0004 : ((b ? bt : jt) & ~32'd3);
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = rom(m_pc[10:2]);
      m_pc = ((m_pc + 32'd4) & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000);
      m_pc4 = m_pc; m_valid = 1;
    end
    #1;
    chk("pc", pc, m_pc);
    chk("imem_addr", {23'b0, imem_addr}, {23'b0, m_pc[10:2]});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc_plus4", if_pc_plus4, m_pc4);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("epc", epc, m_epc);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_boot = 1;
    rst_n = 0; stall = 0; jump_en = 0; branch_en = 0; irq = 0; exc = 0;
    jump_target = 0; branch_target = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h44, 1, 32'h88, 1, 1);
    idle(10);
    for (int i = 0; i < 20 && m_pc != 32'h20; i++) idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 1, 32'h100, 1, 32'h200, 0, 0);
    idle(2);
    cyc(1, 1, 0, 0, 1, 32'h0C, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 1, 32'h40, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 1, 32'h8000_0010, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 32'h8000_0010, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 32'h60, 0, 0);
    cyc(1, 0, 1, 32'h120, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 32'h7F8, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 1, 32'h7FFF_FFFC, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    idle(2);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'h300, 1, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 800; i++) begin
      logic [31:0] bt, jt;
      bt = ($urandom & 32'h0000_0FFF) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0);
      jt = ($urandom & 32'h0000_0FFF) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0);
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, bt,
          $urandom_range(0, 99) < 8, jt, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
